// File: rtl/io_seq_monitor_pkg.sv
// Shared types for the IO sequence monitor: FSM state encoding used by the
// checker, the CSR shim and the bench.
package io_seq_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_DONE_PASS = 2'd2,
        ST_DONE_FAIL = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; output lags input by two clocks.
module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/io_seq_monitor.sv
// On-chip GPIO sequence checker: steps through a table of expected values on a
// synchronised IO slice with masking, glitch filtering and a per-step timeout.
module io_seq_monitor
    import io_seq_monitor_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIMEOUT_W     = 16,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [WIDTH-1:0]         io_in_i,
    input  logic [WIDTH-1:0]         mask_i,
    input  logic                     exp_wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] exp_wr_addr_i,
    input  logic [WIDTH-1:0]         exp_wr_data_i,
    input  logic [$clog2(DEPTH):0]   seq_len_i,
    input  logic [TIMEOUT_W-1:0]     timeout_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic [$clog2(DEPTH):0]   step_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SW  = AW + 1;
    localparam int unsigned SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0]  DEPTH_SW    = SW'(DEPTH);

    seq_state_t           state_q, state_d;
    logic [SW-1:0]        len_q, len_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [SCW-1:0]       stable_q, stable_d;
    logic [SW-1:0]        step_q, step_d;

    logic [WIDTH-1:0]     exp_tbl [DEPTH];
    logic [WIDTH-1:0]     io_s;
    logic                 hit;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (io_in_i),
        .q   (io_s)
    );

    // Writes are blocked only while a check runs, so a write in the start cycle lands first.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                exp_tbl[i] <= '0;
            end
        end else if (exp_wr_en_i && (state_q != ST_WAIT)) begin
            exp_tbl[exp_wr_addr_i] <= exp_wr_data_i;
        end
    end

    assign hit = (((io_s ^ exp_tbl[step_q[AW-1:0]]) & mask_i) == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            tmo_q    <= '0;
            timer_q  <= '0;
            stable_q <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            tmo_q    <= tmo_d;
            timer_q  <= timer_d;
            stable_q <= stable_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        tmo_d    = tmo_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        step_d   = step_q;

        case (state_q)
            ST_WAIT: begin
                // Accept takes priority over a timeout landing in the same cycle.
                if (hit && (stable_q == STABLE_LAST)) begin
                    step_d   = step_q + 1'b1;
                    timer_d  = '0;
                    stable_d = '0;
                    if (step_q == len_q - 1'b1) begin
                        state_d = ST_DONE_PASS;
                    end
                end else begin
                    stable_d = hit ? stable_q + 1'b1 : '0;
                    timer_d  = timer_q + 1'b1;
                    if ((tmo_q != '0) && (timer_q == tmo_q - 1'b1)) begin
                        state_d = ST_DONE_FAIL;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    len_d    = (seq_len_i > DEPTH_SW) ? DEPTH_SW : seq_len_i;
                    tmo_d    = timeout_i;
                    timer_d  = '0;
                    stable_d = '0;
                    step_d   = '0;
                    state_d  = (len_d == '0) ? ST_DONE_PASS : ST_WAIT;
                end
            end
        endcase
    end

    assign busy_o = (state_q == ST_WAIT);
    assign pass_o = (state_q == ST_DONE_PASS);
    assign fail_o = (state_q == ST_DONE_FAIL);
    assign step_o = step_q;

endmodule

// File: tb/tb_io_seq_monitor.sv
// Directed self-checking bench for io_seq_monitor (WIDTH=8, DEPTH=16, STABLE_CYCLES=2).
module tb_io_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] io_in = '0;
    logic [7:0] mask = 8'hFF;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] seq_len = '0;
    logic [15:0] timeout = '0;
    logic       start = 1'b0;
    logic       busy, pass, fail;
    logic [4:0] step;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tbl [12];

    io_seq_monitor #(
        .WIDTH         (8),
        .DEPTH         (16),
        .TIMEOUT_W     (16),
        .STABLE_CYCLES (2)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .io_in_i       (io_in),
        .mask_i        (mask),
        .exp_wr_en_i   (wr_en),
        .exp_wr_addr_i (wr_addr),
        .exp_wr_data_i (wr_data),
        .seq_len_i     (seq_len),
        .timeout_i     (timeout),
        .start_i       (start),
        .busy_o        (busy),
        .pass_o        (pass),
        .fail_o        (fail),
        .step_o        (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 12; i++) begin
            write_entry(4'(i), tbl[i]);
        end
    endtask

    task automatic start_check(input logic [4:0] len, input logic [15:0] tmo);
        seq_len = len;
        timeout = tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [7:0] v, input int n);
        io_in = v;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({busy, pass, fail, step} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b pass=%b fail=%b step=%0d, expected all 0",
                     busy, pass, fail, step);
        end
    endtask

    task automatic test_full_sequence();
        apply_reset();
        mask = 8'hFF;
        io_in = 8'h00;
        load_table();
        start_check(5'd12, 16'd100);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 12; i++) drive(tbl[i], 5);
        repeat (2) tick();
        vectors++;
        if ({pass, fail, busy, step} !== {1'b1, 1'b0, 1'b0, 5'd12}) begin
            miscompares++;
            $display("FAIL seq_pass: got pass=%b fail=%b busy=%b step=%0d, expected 1 0 0 12",
                     pass, fail, busy, step);
        end
    endtask

    task automatic test_timeout();
        bit seen = 0;
        apply_reset();
        io_in = 8'h00;
        load_table();
        start_check(5'd12, 16'd100);
        for (int i = 0; i < 3; i++) drive(tbl[i], 5);
        io_in = 8'h04;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (step == 5'd4) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL tmo_reach_step4: got step=%0d expected 4", step);
        end
        repeat (99) tick();
        vectors++;
        if ({fail, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL tmo_early: got fail=%b busy=%b after 99 cycles, expected 0 1", fail, busy);
        end
        tick();
        vectors++;
        if ({fail, pass, busy, step} !== {1'b1, 1'b0, 1'b0, 5'd4}) begin
            miscompares++;
            $display("FAIL tmo_fire: got fail=%b pass=%b busy=%b step=%0d, expected 1 0 0 4",
                     fail, pass, busy, step);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        io_in = 8'h00;
        load_table();
        start_check(5'd12, 16'd100);
        drive(8'h01, 1);
        drive(8'h00, 6);
        vectors++;
        if (step !== 5'd0) begin
            miscompares++;
            $display("FAIL glitch_reject: got step=%0d expected 0", step);
        end
        drive(8'h01, 2);
        drive(8'h00, 4);
        vectors++;
        if (step !== 5'd1) begin
            miscompares++;
            $display("FAIL glitch_hold2: got step=%0d expected 1", step);
        end
    endtask

    task automatic test_mask();
        apply_reset();
        mask = 8'h0F;
        io_in = 8'h00;
        write_entry(4'd0, 8'h03);
        write_entry(4'd1, 8'h50);
        start_check(5'd2, 16'd0);
        drive(8'hA2, 8);
        vectors++;
        if (step !== 5'd0) begin
            miscompares++;
            $display("FAIL mask_miss: got step=%0d expected 0", step);
        end
        drive(8'hA3, 8);
        vectors++;
        if ({step, busy} !== {5'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL mask_hit: got step=%0d busy=%b expected 1 1", step, busy);
        end
        mask = 8'hFF;
    endtask

    task automatic test_len0_and_no_timeout();
        apply_reset();
        io_in = 8'h5A;
        start_check(5'd0, 16'd0);
        tick();
        vectors++;
        if ({pass, busy, fail, step} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL len0_pass: got pass=%b busy=%b fail=%b step=%0d expected 1 0 0 0",
                     pass, busy, fail, step);
        end
        start_check(5'd1, 16'd0);
        vectors++;
        if ({pass, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL restart_clears: got pass=%b busy=%b expected 0 1", pass, busy);
        end
        repeat (70000) tick();
        vectors++;
        if ({busy, fail, step} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL no_timeout: got busy=%b fail=%b step=%0d expected 1 0 0", busy, fail, step);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        io_in = 8'h00;
        load_table();
        start_check(5'd12, 16'd100);
        for (int i = 0; i < 3; i++) drive(tbl[i], 5);
        vectors++;
        if (step !== 5'd3) begin
            miscompares++;
            $display("FAIL abort_pre_step: got step=%0d expected 3", step);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({busy, pass, fail, step} !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b pass=%b fail=%b step=%0d expected all 0",
                     busy, pass, fail, step);
        end
        rst = 1'b0;
        // A cleared table matches io=00 at step 0; the old table (0x01) would not.
        io_in = 8'h00;
        start_check(5'd1, 16'd0);
        repeat (6) tick();
        vectors++;
        if (pass !== 1'b1) begin
            miscompares++;
            $display("FAIL table_cleared: got pass=%b expected 1", pass);
        end
        io_in = 8'h77;
        start_check(5'd2, 16'd0);
        write_entry(4'd0, 8'h77);
        write_entry(4'd1, 8'h77);
        repeat (10) tick();
        vectors++;
        if ({step, busy, pass} !== {5'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL busy_write_ignored: got step=%0d busy=%b pass=%b expected 0 1 0",
                     step, busy, pass);
        end
        apply_reset();
        drive(8'h33, 4);
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'h33;
        seq_len = 5'd1;
        timeout = 16'd0;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        vectors++;
        if ({pass, step} !== {1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL write_with_start: got pass=%b step=%0d expected 1 1", pass, step);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) tbl[i] = 8'(i + 1);
        tbl[10] = 8'hFF;
        tbl[11] = 8'h00;
        test_reset();
        test_full_sequence();
        test_timeout();
        test_glitch();
        test_mask();
        test_len0_and_no_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
